// File: rtl/posit_seq_decoder_if.sv
// posit_seq_decoder_if: request/result bundle between an operand source and the posit decoder
//   master (requester): drives start, posit_in; observes busy, done and the decoded fields
//   slave  (decoder):   observes start, posit_in; drives busy, done, sign, zero, nar,
//                       regime (signed k), exponent, mantissa ({1'b1, fraction}, left-aligned)
interface posit_seq_decoder_if #(
  parameter int N  = 32,
  parameter int ES = 2
);
  localparam int KW = $clog2(N) + 1;
  localparam int MW = N - ES - 2;
  logic                 start;
  logic [N-1:0]         posit_in;
  logic                 busy;
  logic                 done;
  logic                 sign;
  logic                 zero;
  logic                 nar;
  logic signed [KW-1:0] regime;
  logic [ES-1:0]        exponent;
  logic [MW-1:0]        mantissa;
  modport master (output start, posit_in,
                  input  busy, done, sign, zero, nar, regime, exponent, mantissa);
  modport slave  (input  start, posit_in,
                  output busy, done, sign, zero, nar, regime, exponent, mantissa);
endinterface

// File: rtl/posit_seq_decoder.sv
// posit_seq_decoder: multi-cycle posit operand decoder, regime extracted one bit per cycle
//   clk, rst_n (async, active-low) plain ports; bus (slave) carries start/posit_in in and
//   busy/done/sign/zero/nar/regime/exponent/mantissa out. Result fields load on entry to DONE
//   and hold until the next DONE.
module posit_seq_decoder #(
  parameter int N  = 32,
  parameter int ES = 2
) (
  input logic clk,
  input logic rst_n,
  posit_seq_decoder_if.slave bus
);
  localparam int KW = $clog2(N) + 1;
  localparam int MW = N - ES - 2;
  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, CHECK, RUN, EXTRACT, DONE} state_t;
  state_t               state, state_n;
  logic [N-1:0]         op, op_n, work, work_n;
  logic [N-2:0]         mag;
  logic [N-4:0]         tail;
  logic                 r0, r0_n, sign_q, sign_n, zero_q, zero_n, nar_q, nar_n;
  logic [KW-1:0]        cnt, cnt_n;
  logic signed [KW-1:0] regime_q, regime_n;
  logic [ES-1:0]        exp_q, exp_n;
  logic [MW-1:0]        mant_q, mant_n;
  // Only the low N-1 bits of |operand| matter: the MSB is shifted out when work is formed,
  // and for the most-negative non-NaR operand the magnitude still fits.
  assign mag  = op[N-1] ? (~op[N-2:0] + (N-1)'(1)) : op[N-2:0];
  // A terminating bit (work MSB differs from the run polarity) is skipped before reading
  // exponent and fraction; a capped run has none.
  assign tail = (work[N-1] != r0) ? work[N-2:2] : work[N-1:3];
  always_comb begin
    state_n  = state;
    op_n     = op;
    work_n   = work;
    r0_n     = r0;
    cnt_n    = cnt;
    sign_n   = sign_q;
    zero_n   = zero_q;
    nar_n    = nar_q;
    regime_n = regime_q;
    exp_n    = exp_q;
    mant_n   = mant_q;
    case (state)
      IDLE: if (bus.start) begin
        op_n    = bus.posit_in;
        state_n = CHECK;
      end
      CHECK: if (op == '0 || op == NAR) begin
        zero_n   = (op == '0);
        nar_n    = (op == NAR);
        sign_n   = 1'b0;
        regime_n = '0;
        exp_n    = '0;
        mant_n   = '0;
        state_n  = DONE;
      end else begin
        work_n  = {mag, 1'b0};
        r0_n    = mag[N-2];
        cnt_n   = '0;
        state_n = RUN;
      end
      RUN: begin
        cnt_n   = cnt + KW'(1);
        work_n  = {work[N-2:0], 1'b0};
        state_n = (work[N-2] != r0 || cnt == KW'(N-2)) ? EXTRACT : RUN;
      end
      EXTRACT: begin
        zero_n   = 1'b0;
        nar_n    = 1'b0;
        sign_n   = op[N-1];
        regime_n = r0 ? cnt - KW'(1) : -cnt;
        exp_n    = tail[N-4 -: ES];
        mant_n   = {1'b1, tail[MW-2:0]};
        state_n  = DONE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      op       <= '0;
      work     <= '0;
      r0       <= 1'b0;
      cnt      <= '0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      nar_q    <= 1'b0;
      regime_q <= '0;
      exp_q    <= '0;
      mant_q   <= '0;
    end else begin
      state    <= state_n;
      op       <= op_n;
      work     <= work_n;
      r0       <= r0_n;
      cnt      <= cnt_n;
      sign_q   <= sign_n;
      zero_q   <= zero_n;
      nar_q    <= nar_n;
      regime_q <= regime_n;
      exp_q    <= exp_n;
      mant_q   <= mant_n;
    end
  assign bus.busy     = (state != IDLE) && (state != DONE);
  assign bus.done     = (state == DONE);
  assign bus.sign     = sign_q;
  assign bus.zero     = zero_q;
  assign bus.nar      = nar_q;
  assign bus.regime   = regime_q;
  assign bus.exponent = exp_q;
  assign bus.mantissa = mant_q;
endmodule

// File: tb/tb_posit_seq_decoder.sv
// tb_posit_seq_decoder: scoreboard bench for posit_seq_decoder (fixed vectors, random operands, control cases)
module tb_posit_seq_decoder;
  localparam int N = 32, ES = 2, KW = 6, MW = 28;
  typedef struct {
    logic          s, z, n;
    logic [KW-1:0] k;
    logic [ES-1:0] e;
    logic [MW-1:0] m;
    int            lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  posit_seq_decoder_if #(.N(N), .ES(ES)) bus ();
  posit_seq_decoder #(.N(N), .ES(ES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask
  function automatic exp_t mk(logic s, logic z, logic n, int k, int e, logic [MW-1:0] m, int lat);
    exp_t r;
    r.s = s; r.z = z; r.n = n; r.k = KW'(k); r.e = ES'(e); r.m = m; r.lat = lat;
    return r;
  endfunction
  function automatic exp_t model(logic [31:0] p);
    logic [31:0] a;
    logic [63:0] t;
    logic        r0;
    int          m;
    if (p == 32'h0) return mk(0, 1, 0, 0, 0, '0, 1);
    if (p == 32'h8000_0000) return mk(0, 0, 1, 0, 0, '0, 1);
    a  = p[31] ? -p : p;
    r0 = a[30];
    m  = 0;
    while (m < 31 && a[30-m] == r0) m++;
    t = {a, 32'h0} << (m + 2);
    return mk(p[31], 0, 0, r0 ? m - 1 : -m, int'(t[63:62]), {1'b1, t[61:35]}, m + 2);
  endfunction
  task automatic check_idle_zero(input string tag);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_fields"}, {bus.sign, bus.zero, bus.nar, $unsigned(bus.regime), bus.exponent, bus.mantissa}, 0);
  endtask
  task automatic run_op(input logic [31:0] p, input exp_t e, input bit poke);
    exp_t g;
    int   lat;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b1;
    bus.posit_in = p;
    @(negedge clk);
    bus.start = 1'b0;
    bus.posit_in = $urandom;
    chk("busy_after_start", bus.busy, 1);
    if (poke) begin
      bus.start = 1'b1;
      bus.posit_in = 32'h0000_0001;
    end
    lat = 0;
    do begin
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
    end while (!bus.done && lat < 40);
    g = sb.pop_front();
    chk("done_seen", bus.done, 1);
    chk("latency", lat, g.lat);
    chk("busy_at_done", bus.busy, 0);
    chk("sign", bus.sign, g.s);
    chk("zero", bus.zero, g.z);
    chk("nar", bus.nar, g.n);
    chk("regime", $unsigned(bus.regime), g.k);
    chk("exponent", bus.exponent, g.e);
    chk("mantissa", bus.mantissa, g.m);
    @(negedge clk);
    chk("done_pulse", bus.done, 0);
    chk("hold", {$unsigned(bus.regime), bus.exponent, bus.mantissa}, {g.k, g.e, g.m});
  endtask
  initial begin
    logic [31:0] p;
    bus.start = 1'b0;
    bus.posit_in = '0;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    rst_n = 1'b1;
    run_op(32'h0000_0000, mk(0, 1, 0, 0, 0, '0, 1), 0);
    run_op(32'h8000_0000, mk(0, 0, 1, 0, 0, '0, 1), 0);
    run_op(32'h4000_0000, mk(0, 0, 0, 0, 0, 28'h800_0000, 3), 0);
    run_op(32'hC000_0000, mk(1, 0, 0, 0, 0, 28'h800_0000, 3), 0);
    run_op(32'h5A00_0000, mk(0, 0, 0, 0, 3, 28'hA00_0000, 3), 0);
    run_op(32'h7FFF_FFFF, mk(0, 0, 0, 30, 0, 28'h800_0000, 33), 0);
    run_op(32'h0000_0001, mk(0, 0, 0, -30, 0, 28'h800_0000, 32), 0);
    run_op(32'h4000_0000, mk(0, 0, 0, 0, 0, 28'h800_0000, 3), 1);
    run_op(32'h0000_0000, mk(0, 1, 0, 0, 0, '0, 1), 1);
    run_op(32'h8000_0001, model(32'h8000_0001), 0);
    run_op(32'hFFFF_FFFF, model(32'hFFFF_FFFF), 0);
    for (int i = 0; i < 24; i++) begin
      p = $urandom;
      run_op(p, model(p), i[0]);
    end
    @(negedge clk);
    bus.start = 1'b1;
    bus.posit_in = 32'h0000_0001;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy_mid_run", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check_idle_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) break;
    end
    check_idle_zero("post_abort");
    run_op(32'h5A00_0000, mk(0, 0, 0, 0, 3, 28'hA00_0000, 3), 0);
    run_op(32'hC000_0000, mk(1, 0, 0, 0, 0, 28'h800_0000, 3), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
